// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite draw scheduler: sprite ROM word layout,
// default screen geometry and the scheduler FSM state encoding.
package sprite_pkg;

  // Sprite ROM word: [15] rsvd, [14:12] colour, [11:8] dy, [7:4] dx, [3:1] rsvd, [0] valid
  localparam int COL_HI    = 14;
  localparam int COL_LO    = 12;
  localparam int DY_HI     = 11;
  localparam int DY_LO     = 8;
  localparam int DX_HI     = 7;
  localparam int DX_LO     = 4;
  localparam int VALID_BIT = 0;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN1 = 3'd2,
    DRAIN2 = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after ptr
// (wrapping) wins; nothing is granted while en is low.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares one VGA pixel-write port between NUM_REQ sprite drawers: arbitrates,
// walks the winner's sprite ROM one word per cycle and emits clipped pixel writes.
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SPRITE_WORDS = 220,
  parameter int ADDR_W       = 8,
  parameter int SCREEN_W     = SCREEN_W_DEFAULT,
  parameter int SCREEN_H     = SCREEN_H_DEFAULT,
  parameter int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_x,
  input  logic [NUM_REQ*7-1:0] req_y,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [IDX_W-1:0]     rom_sel,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [15:0]          rom_data,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 writeEn,
  output logic [2:0]           fsm_state
);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [7:0]         ox;
  logic [6:0]         oy;
  logic               rd_valid;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [7:0]         sel_x;
  logic [6:0]         sel_y;

  logic [8:0]         px;
  logic [8:0]         py;
  logic               pix_ok;
  logic               word_unused;

  assign fsm_state = state;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .en    (state == IDLE),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_x = req_x[8*i +: 8];
        sel_y = req_y[7*i +: 7];
      end
    end
  end

  // rd_valid marks cycles where rom_data carries a word addressed during RUN.
  assign px     = {1'b0, ox} + 9'(rom_data[DX_HI:DX_LO]);
  assign py     = {2'b00, oy} + 9'(rom_data[DY_HI:DY_LO]);
  assign pix_ok = rd_valid && rom_data[VALID_BIT] &&
                  (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));

  assign word_unused = ^{rom_data[15], rom_data[3:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      ox       <= '0;
      oy       <= '0;
      rd_valid <= 1'b0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      rom_sel  <= '0;
      rom_addr <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      writeEn  <= 1'b0;
    end else begin
      done     <= '0;
      rd_valid <= (state == RUN);
      writeEn  <= pix_ok;
      if (pix_ok) begin
        x      <= px[7:0];
        y      <= py[6:0];
        colour <= rom_data[COL_HI:COL_LO];
      end

      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= arb_grant;
            rom_sel  <= arb_idx;
            ox       <= sel_x;
            oy       <= sel_y;
            rom_addr <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (rom_addr == ADDR_W'(SPRITE_WORDS - 1)) state <= DRAIN1;
          else rom_addr <= rom_addr + 1'b1;
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: begin
          done  <= grant;
          state <= DONE;
        end
        DONE: begin
          grant  <= '0;
          busy   <= 1'b0;
          rr_ptr <= (int'(rom_sel) == NUM_REQ - 1) ? '0 : rom_sel + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler with a behavioural synchronous ROM
// per requester and a queue of expected pixel writes tagged with cycle offsets.
module tb_sprite_draw_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  rom_sel;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic [2:0]  fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int g_cur  = 0;
  int wr_cnt = 0;
  int g_first;

  // Expected write: {offset from G, x, y, colour}
  logic [25:0] exp_q[$];

  sprite_draw_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .rom_sel   (rom_sel),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .writeEn   (writeEn),
    .fsm_state (fsm_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Sprite k: colour k%8, dy k/16, dx k%16; ROM 1 leaves every word with k%5==3 empty.
  function automatic logic [15:0] rom_word(input logic [1:0] sel, input logic [7:0] a);
    int   k;
    logic v;
    k = int'(a);
    v = !(sel == 2'd1 && (k % 5) == 3);
    return {1'b0, 3'(k % 8), 4'(k / 16), 4'(k % 16), 3'b000, v};
  endfunction

  always @(posedge clock) rom_data <= rom_word(rom_sel, rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write must match the next expected entry, including its cycle
  always @(negedge clock) begin
    logic [31:0] obs;
    logic [31:0] exp;
    if (writeEn === 1'b1) begin
      wr_cnt++;
      obs = {6'd0, 8'(cyc - g_cur), x, y, colour};
      exp = (exp_q.size() != 0) ? {6'd0, exp_q.pop_front()} : 'x;
      check("pixel_write", obs, exp);
    end
  end

  task automatic load_model(input int idx, input logic [7:0] ox, input logic [6:0] oy);
    logic [15:0] w;
    logic [8:0]  px;
    logic [8:0]  py;
    for (int k = 0; k < 220; k++) begin
      w  = rom_word(2'(idx), 8'(k));
      px = 9'(ox) + 9'(w[7:4]);
      py = 9'(oy) + 9'(w[11:8]);
      if (w[0] && px < 9'd160 && py < 9'd120)
        exp_q.push_back({8'(k + 2), px[7:0], py[6:0], w[14:12]});
    end
  endtask

  // mode 0: normal draw, mode 1: drop req and move req_x at G+50, mode 2: reset at G+100
  task automatic run_draw(input int idx, input logic [7:0] ox, input logic [6:0] oy,
                          input int mode, input int exp_n);
    int         t;
    int         wr0;
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    t  = 0;
    while (grant === 4'd0 && t < 10) begin
      @(negedge clock);
      t++;
    end
    check("grant_onehot", 32'(grant), 32'(oh));
    g_cur = cyc;
    wr0   = wr_cnt;
    check("rom_sel_at_g", 32'(rom_sel), 32'(idx));
    check("busy_at_g", 32'(busy), 32'd1);
    check("rom_addr_at_g", 32'(rom_addr), 32'd0);
    load_model(idx, ox, oy);

    if (mode == 2) begin
      repeat (100) @(negedge clock);
      check("rom_addr_g100", 32'(rom_addr), 32'd100);
      reset = 1'b1;
      @(negedge clock);
      check("rst_outputs", {grant, done, busy, rom_sel, rom_addr, x, y, colour, writeEn},
            32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);
      exp_q.delete();
      reset = 1'b0;
      return;
    end

    if (mode == 1) begin
      repeat (50) @(negedge clock);
      req[idx]          = 1'b0;
      req_x[8*idx +: 8] = 8'd3;
    end

    t = 0;
    while (done === 4'd0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    check("done_cycle", 32'(cyc - g_cur), 32'd222);
    check("done_onehot", 32'(done), 32'(oh));
    check("busy_at_done", 32'(busy), 32'd1);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(wr_cnt - wr0), 32'(exp_n));
    req[idx] = 1'b0;
    @(negedge clock);
    check("after_done", {28'd0, grant[2:0], busy}, 32'd0);
    check("done_cleared", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    req_x = '0;
    req_y = '0;
    repeat (3) @(negedge clock);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_sel", 32'(rom_sel), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_xyc", {14'd0, x, y, colour}, 32'd0);
    check("rst_writeen", 32'(writeEn), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // single draw, origin (10,20): all 220 words land on screen
    req_x[7:0] = 8'd10;
    req_y[6:0] = 7'd20;
    req[0]     = 1'b1;
    run_draw(0, 8'd10, 7'd20, 0, 220);

    // clipping near the right/bottom edge: dx<=4 and dy<=9 survive -> 50 writes
    req_x[23:16] = 8'd155;
    req_y[20:14] = 7'd110;
    req[2]       = 1'b1;
    run_draw(2, 8'd155, 7'd110, 0, 50);

    // req dropped and origin moved mid-draw: original origin still used
    req_x[31:24] = 8'd40;
    req_y[27:21] = 7'd50;
    req[3]       = 1'b1;
    run_draw(3, 8'd40, 7'd50, 1, 220);

    // reset mid-draw on requester 1 (skips words with k%5==3), then re-served
    req_x[15:8]  = 8'd0;
    req_y[13:7]  = 7'd0;
    req[1]       = 1'b1;
    run_draw(1, 8'd0, 7'd0, 2, 0);
    run_draw(1, 8'd0, 7'd0, 0, 176);

    // contention after reset: requester 1 before requester 2, back to back
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    req_x[23:16] = 8'd150;
    req_y[20:14] = 7'd0;
    req          = 4'b0110;
    run_draw(1, 8'd0, 7'd0, 0, 176);
    g_first = g_cur;
    run_draw(2, 8'd150, 7'd0, 0, 140);
    check("back_to_back_gap", 32'(g_cur - g_first), 32'd224);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
